// File: rtl/edge_gen_pkg.sv
// Shared types, constants and helpers for the four-channel edge/pulse generator.
package edge_gen_pkg;

    // Number of independent generator channels in the top level.
    localparam int NUM_CH = 4;

    // Per-channel phase: idle, driving the high phase, or holding the low gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } chan_state_t;

    // A programmed length of zero behaves exactly like a length of one, so a
    // phase always lasts at least one cycle and the down-counter reload
    // (length - 1) can never underflow.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/edge_gen_chan.sv
// One generator channel: turns a one-cycle trigger into a high phase followed
// by a guaranteed low gap, with a single-deep request queue and a sticky
// overrun flag for triggers that could not be queued.
module edge_gen_chan
    import edge_gen_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic [CW-1:0] high_len,
    input  logic [CW-1:0] gap_len,
    input  logic          clr_ovr,
    output logic          level,
    output logic          busy,
    output logic          overrun
);

    chan_state_t   state_q;
    chan_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pending_q;
    logic          pending_d;
    logic          overrun_q;
    logic          overrun_d;

    logic [CW-1:0] high_reload;
    logic [CW-1:0] gap_reload;
    logic          cnt_zero;
    logic          final_gap;
    logic          restart;
    logic          queue_req;
    logic          drop_req;

    // The counter holds "cycles remaining after this one", so each phase
    // reloads with its clamped length minus one.
    assign high_reload = CW'(clamp_len(32'(high_len)) - 32'd1);
    assign gap_reload  = CW'(clamp_len(32'(gap_len)) - 32'd1);

    assign cnt_zero  = (cnt_q == '0);
    assign final_gap = (state_q == GAP) && cnt_zero;

    // The last gap cycle restarts the pulse if anything is waiting or a fresh
    // trigger arrives right now; a trigger here is taken directly and never
    // touches the pending slot.
    assign restart = final_gap && (pending_q || trig);

    // A trigger during the high phase or an earlier gap cycle must wait; it
    // goes into the pending slot, or is dropped if the slot is already full.
    assign queue_req = trig && ((state_q == HIGH) || ((state_q == GAP) && !cnt_zero));
    assign drop_req  = queue_req && pending_q;

    // State register: all channel flops, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: walk IDLE -> HIGH -> GAP and either restart or idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = restart ? HIGH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Phase counter: load the sampled length on every phase entry, otherwise
    // count down towards zero.
    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    cnt_d = high_reload;
                end
            end
            HIGH: begin
                cnt_d = cnt_zero ? gap_reload : (cnt_q - CW'(1));
            end
            GAP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (restart) begin
                    cnt_d = high_reload;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Request bookkeeping: the pending slot is consumed by a restart and
    // filled by a busy-time trigger; a set overrun beats a same-cycle clear.
    always_comb begin
        pending_d = pending_q;
        if (restart) begin
            pending_d = 1'b0;
        end else if (queue_req && !pending_q) begin
            pending_d = 1'b1;
        end

        overrun_d = overrun_q;
        if (drop_req) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // Output decode straight from the registered state.
    always_comb begin
        level   = (state_q == HIGH);
        busy    = (state_q != IDLE) || pending_q;
        overrun = overrun_q;
    end

endmodule

// File: rtl/edge_gen_4bit.sv
// Four-channel registered edge/pulse generator. Each channel runs on its own;
// the length inputs and the overrun clear are shared by all of them.
module edge_gen_4bit
    import edge_gen_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trig,
    input  logic [CW-1:0]     high_len,
    input  logic [CW-1:0]     gap_len,
    input  logic              clr_ovr,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] overrun
);

    // One independent generator per trigger bit.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        edge_gen_chan #(
            .CW(CW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .trig    (trig[i]),
            .high_len(high_len),
            .gap_len (gap_len),
            .clr_ovr (clr_ovr),
            .level   (level[i]),
            .busy    (busy[i]),
            .overrun (overrun[i])
        );
    end

endmodule

// File: tb/tb_edge_gen_4bit.sv
// Self-checking bench for edge_gen_4bit. Stimulus for cycle c is driven on the
// falling edge inside cycle c, the expected outputs for cycle c+1 are queued at
// the same moment, and they are popped and compared on the next falling edge.
module tb_edge_gen_4bit;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] busy;
        logic [3:0] ovr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] trig;
    logic [3:0] high_len;
    logic [3:0] gap_len;
    logic       clr_ovr;
    logic [3:0] level;
    logic [3:0] busy;
    logic [3:0] overrun;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    edge_gen_4bit #(
        .CW(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .high_len(high_len),
        .gap_len (gap_len),
        .clr_ovr (clr_ovr),
        .level   (level),
        .busy    (busy),
        .overrun (overrun)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        $display("[TB] reset state");
        rst      = 1'b0;
        trig     = 4'b0000;
        clr_ovr  = 1'b0;
        high_len = 4'd3;
        gap_len  = 4'd2;
        #3;
        vectors++;
        if (level !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_level: got %b want 0000", level);
        end
        vectors++;
        if (busy !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got %b want 0000", busy);
        end
        vectors++;
        if (overrun !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_overrun: got %b want 0000", overrun);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({level, busy, overrun} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %b/%b/%b want all zero", level, busy, overrun);
        end
    endtask

    task automatic test_single_pulse();
        exp_t e;
        int   k;
        $display("[TB] single pulse");
        high_len = 4'd3;
        gap_len  = 4'd2;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb.pop_front();
                vectors++;
                if (level !== e.level) begin
                    miscompares++;
                    $display("[TB] FAIL single_level cycle %0d: got %b want %b", c, level, e.level);
                end
                vectors++;
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("[TB] FAIL single_busy cycle %0d: got %b want %b", c, busy, e.busy);
                end
                vectors++;
                if (overrun !== e.ovr) begin
                    miscompares++;
                    $display("[TB] FAIL single_overrun cycle %0d: got %b want %b", c, overrun, e.ovr);
                end
            end
            if (c < 8) begin
                trig = (c == 0) ? 4'b0001 : 4'b0000;
                if (c == 2) high_len = 4'd9;
                if (c == 4) gap_len = 4'd9;
                k = c + 1;
                e.level = (k inside {[1:3]}) ? 4'b0001 : 4'b0000;
                e.busy  = (k inside {[1:5]}) ? 4'b0001 : 4'b0000;
                e.ovr   = 4'b0000;
                sb.push_back(e);
            end
        end
        trig     = 4'b0000;
        high_len = 4'd3;
        gap_len  = 4'd2;
    endtask

    task automatic test_queued_retrigger();
        exp_t e;
        int   k;
        $display("[TB] queued retrigger");
        high_len = 4'd3;
        gap_len  = 4'd2;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb.pop_front();
                vectors++;
                if (level !== e.level) begin
                    miscompares++;
                    $display("[TB] FAIL queued_level cycle %0d: got %b want %b", c, level, e.level);
                end
                vectors++;
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("[TB] FAIL queued_busy cycle %0d: got %b want %b", c, busy, e.busy);
                end
                vectors++;
                if (overrun !== e.ovr) begin
                    miscompares++;
                    $display("[TB] FAIL queued_overrun cycle %0d: got %b want %b", c, overrun, e.ovr);
                end
            end
            if (c < 12) begin
                trig = (c <= 1) ? 4'b0001 : 4'b0000;
                k = c + 1;
                e.level = (k inside {[1:3], [6:8]}) ? 4'b0001 : 4'b0000;
                e.busy  = (k inside {[1:10]}) ? 4'b0001 : 4'b0000;
                e.ovr   = 4'b0000;
                sb.push_back(e);
            end
        end
        trig = 4'b0000;
    endtask

    task automatic test_overrun();
        exp_t e;
        int   k;
        $display("[TB] overrun and clear");
        high_len = 4'd3;
        gap_len  = 4'd2;
        for (int c = 0; c <= 27; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb.pop_front();
                vectors++;
                if (level !== e.level) begin
                    miscompares++;
                    $display("[TB] FAIL ovr_level cycle %0d: got %b want %b", c, level, e.level);
                end
                vectors++;
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("[TB] FAIL ovr_busy cycle %0d: got %b want %b", c, busy, e.busy);
                end
                vectors++;
                if (overrun !== e.ovr) begin
                    miscompares++;
                    $display("[TB] FAIL ovr_flag cycle %0d: got %b want %b", c, overrun, e.ovr);
                end
            end
            if (c < 27) begin
                trig    = (c inside {0, 1, 2, 14, 15, 16}) ? 4'b0001 : 4'b0000;
                clr_ovr = (c inside {12, 16, 25}) ? 1'b1 : 1'b0;
                k = c + 1;
                e.level = (k inside {[1:3], [6:8], [15:17], [20:22]}) ? 4'b0001 : 4'b0000;
                e.busy  = (k inside {[1:10], [15:24]}) ? 4'b0001 : 4'b0000;
                e.ovr   = (k inside {[3:12], [17:25]}) ? 4'b0001 : 4'b0000;
                sb.push_back(e);
            end
        end
        trig    = 4'b0000;
        clr_ovr = 1'b0;
    endtask

    task automatic test_zero_lengths();
        exp_t e;
        int   k;
        $display("[TB] zero lengths");
        high_len = 4'd0;
        gap_len  = 4'd0;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb.pop_front();
                vectors++;
                if (level !== e.level) begin
                    miscompares++;
                    $display("[TB] FAIL zero_level cycle %0d: got %b want %b", c, level, e.level);
                end
                vectors++;
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("[TB] FAIL zero_busy cycle %0d: got %b want %b", c, busy, e.busy);
                end
                vectors++;
                if (overrun !== e.ovr) begin
                    miscompares++;
                    $display("[TB] FAIL zero_overrun cycle %0d: got %b want %b", c, overrun, e.ovr);
                end
            end
            if (c < 11) begin
                trig = (c <= 7) ? 4'b0010 : 4'b0000;
                k = c + 1;
                e.level = (k inside {1, 3, 5, 7, 9}) ? 4'b0010 : 4'b0000;
                e.busy  = (k inside {[1:10]}) ? 4'b0010 : 4'b0000;
                e.ovr   = 4'b0000;
                sb.push_back(e);
            end
        end
        trig     = 4'b0000;
        high_len = 4'd3;
        gap_len  = 4'd2;
    endtask

    task automatic test_independence();
        exp_t e;
        $display("[TB] channel independence");
        high_len = 4'd2;
        gap_len  = 4'd1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb.pop_front();
                vectors++;
                if (level !== e.level) begin
                    miscompares++;
                    $display("[TB] FAIL indep_level cycle %0d: got %b want %b", c, level, e.level);
                end
                vectors++;
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("[TB] FAIL indep_busy cycle %0d: got %b want %b", c, busy, e.busy);
                end
                vectors++;
                if (overrun !== e.ovr) begin
                    miscompares++;
                    $display("[TB] FAIL indep_overrun cycle %0d: got %b want %b", c, overrun, e.ovr);
                end
            end
            if (c < 6) begin
                case (c)
                    0:       trig = 4'b1010;
                    1:       trig = 4'b0001;
                    default: trig = 4'b0000;
                endcase
                e.ovr = 4'b0000;
                case (c + 1)
                    1:       begin e.level = 4'b1010; e.busy = 4'b1010; end
                    2:       begin e.level = 4'b1011; e.busy = 4'b1011; end
                    3:       begin e.level = 4'b0001; e.busy = 4'b1011; end
                    4:       begin e.level = 4'b0000; e.busy = 4'b0001; end
                    default: begin e.level = 4'b0000; e.busy = 4'b0000; end
                endcase
                sb.push_back(e);
            end
        end
        trig     = 4'b0000;
        high_len = 4'd3;
        gap_len  = 4'd2;
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   k;
        $display("[TB] asynchronous reset mid-pulse");
        high_len = 4'd3;
        gap_len  = 4'd2;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                e = sb.pop_front();
                vectors++;
                if (level !== e.level) begin
                    miscompares++;
                    $display("[TB] FAIL arst_pre_level cycle %0d: got %b want %b", c, level, e.level);
                end
                vectors++;
                if (busy !== e.busy) begin
                    miscompares++;
                    $display("[TB] FAIL arst_pre_busy cycle %0d: got %b want %b", c, busy, e.busy);
                end
                vectors++;
                if (overrun !== e.ovr) begin
                    miscompares++;
                    $display("[TB] FAIL arst_pre_overrun cycle %0d: got %b want %b", c, overrun, e.ovr);
                end
            end
            if (c < 3) begin
                trig = 4'b1111;
                k = c + 1;
                e.level = 4'b1111;
                e.busy  = 4'b1111;
                e.ovr   = (k >= 3) ? 4'b1111 : 4'b0000;
                sb.push_back(e);
            end else begin
                trig = 4'b0000;
            end
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (level !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL arst_level: got %b want 0000", level);
        end
        vectors++;
        if (busy !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL arst_busy: got %b want 0000", busy);
        end
        vectors++;
        if (overrun !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL arst_overrun: got %b want 0000", overrun);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Run every scenario in order, then report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_pulse();
        test_queued_retrigger();
        test_overrun();
        test_zero_lengths();
        test_independence();
        test_async_reset();
        test_single_pulse();
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
